// File: rtl/seg_display_arbiter_pkg.sv
// Shared constants for the seven-segment display arbiter: source indices,
// arbitration state encodings, nibble codes and segment glyphs.
package seg_display_arbiter_pkg;

    localparam int unsigned NUM_SRC = 3;

    localparam int unsigned SRC_TIME  = 0;
    localparam int unsigned SRC_SW    = 1;
    localparam int unsigned SRC_ALERT = 2;

    // Encodings equal the source index so the state drives owner directly.
    typedef enum logic [1:0] {
        StShowTime  = 2'd0,
        StShowSw    = 2'd1,
        StShowAlert = 2'd2
    } state_e;

    localparam logic [3:0] NIB_DASH  = 4'hA;
    localparam logic [3:0] NIB_BLANK = 4'hF;

    localparam logic [7:0] GLYPH_0     = 8'hFC;
    localparam logic [7:0] GLYPH_1     = 8'h60;
    localparam logic [7:0] GLYPH_2     = 8'hDA;
    localparam logic [7:0] GLYPH_3     = 8'hF2;
    localparam logic [7:0] GLYPH_4     = 8'h66;
    localparam logic [7:0] GLYPH_5     = 8'hB6;
    localparam logic [7:0] GLYPH_6     = 8'hBE;
    localparam logic [7:0] GLYPH_7     = 8'hE0;
    localparam logic [7:0] GLYPH_8     = 8'hFE;
    localparam logic [7:0] GLYPH_9     = 8'hF6;
    localparam logic [7:0] GLYPH_DASH  = 8'h02;
    localparam logic [7:0] GLYPH_BLANK = 8'h00;

endpackage

// File: rtl/seg_display_arbiter_seg7_decode.sv
// Combinational nibble to seven-segment decoder {a,b,c,d,e,f,g,dp}, active-high.
// 0xB..0xF decode to blank.
module seg7_decode
    import seg_display_arbiter_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = GLYPH_BLANK;
        case (nibble_i)
            4'h0:     seg_o = GLYPH_0;
            4'h1:     seg_o = GLYPH_1;
            4'h2:     seg_o = GLYPH_2;
            4'h3:     seg_o = GLYPH_3;
            4'h4:     seg_o = GLYPH_4;
            4'h5:     seg_o = GLYPH_5;
            4'h6:     seg_o = GLYPH_6;
            4'h7:     seg_o = GLYPH_7;
            4'h8:     seg_o = GLYPH_8;
            4'h9:     seg_o = GLYPH_9;
            NIB_DASH: seg_o = GLYPH_DASH;
            default:  seg_o = GLYPH_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// Shares an 8-digit seven-segment display between time, stopwatch and alert
// sources: digit scan, frame-boundary priority arbitration and blink masking.
module seg_display_arbiter
    import seg_display_arbiter_pkg::*;
#(
    parameter int unsigned SCAN_DIV         = 100_000,
    parameter int unsigned BLINK_HALF       = 50_000_000,
    parameter int unsigned ALERT_MIN_FRAMES = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req_i,
    input  logic [95:0] digits_i,
    input  logic [23:0] blink_i,
    output logic [7:0]  seg_data_o,
    output logic [7:0]  seg_which_o,
    output logic [1:0]  owner_o,
    output logic [2:0]  grant_o
);

    localparam int unsigned DivW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BlinkW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int unsigned HoldW  = $clog2(ALERT_MIN_FRAMES + 1);

    logic [DivW-1:0]   div_q, div_d;
    logic [2:0]        slot_q, slot_d;
    logic [BlinkW-1:0] bcnt_q, bcnt_d;
    logic              phase_q, phase_d;
    logic              started_q, started_d;
    logic [HoldW-1:0]  hold_q, hold_d;
    state_e            state_q, state_d;
    logic [2:0]        grant_q, grant_d;
    logic [7:0]        seg_which_q, seg_which_d;
    logic [7:0]        seg_data_q, seg_data_d;

    logic        tick;
    logic        frame_end;
    logic [31:0] src_digits;
    logic [7:0]  src_blink;
    logic [3:0]  cur_nib;
    logic [7:0]  cur_glyph;

    assign tick      = (div_q == DivW'(SCAN_DIV - 1));
    assign frame_end = tick && (slot_q == 3'd7);

    always_comb begin
        div_d     = tick ? '0 : div_q + 1'b1;
        slot_d    = tick ? slot_q + 3'd1 : slot_q;
        started_d = started_q | tick;
        if (bcnt_q == BlinkW'(BLINK_HALF - 1)) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
        end else begin
            bcnt_d  = bcnt_q + 1'b1;
            phase_d = phase_q;
        end
    end

    // Hold count is decremented before the exit test, so the alert owns the
    // display for exactly ALERT_MIN_FRAMES frames after being granted.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        if (frame_end) begin
            case (state_q)
                StShowAlert: begin
                    hold_d = (hold_q != '0) ? hold_q - 1'b1 : '0;
                    if (hold_d == '0 && !req_i[SRC_ALERT]) begin
                        state_d = req_i[SRC_SW] ? StShowSw : StShowTime;
                    end
                end
                default: begin
                    if (req_i[SRC_ALERT]) begin
                        state_d = StShowAlert;
                        hold_d  = HoldW'(ALERT_MIN_FRAMES);
                    end else if (req_i[SRC_SW]) begin
                        state_d = StShowSw;
                    end else begin
                        state_d = StShowTime;
                    end
                end
            endcase
        end
        grant_d = (state_d != state_q) ? (3'b001 << state_d) : 3'b000;
    end

    always_comb begin
        src_digits = digits_i[31:0];
        src_blink  = blink_i[7:0];
        case (state_q)
            StShowSw: begin
                src_digits = digits_i[63:32];
                src_blink  = blink_i[15:8];
            end
            StShowAlert: begin
                src_digits = digits_i[95:64];
                src_blink  = blink_i[23:16];
            end
            default: ;
        endcase
    end

    assign cur_nib = src_digits[{slot_q, 2'b00} +: 4];

    seg7_decode u_seg7_decode (
        .nibble_i (cur_nib),
        .seg_o    (cur_glyph)
    );

    // Outputs stay dark until the scan has produced its first tick.
    always_comb begin
        seg_which_d = 8'h00;
        seg_data_d  = 8'h00;
        if (started_q) begin
            seg_data_d = cur_glyph;
            if (!(phase_q && src_blink[slot_q])) begin
                seg_which_d = 8'h80 >> slot_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q       <= '0;
            slot_q      <= '0;
            bcnt_q      <= '0;
            phase_q     <= 1'b0;
            started_q   <= 1'b0;
            hold_q      <= '0;
            state_q     <= StShowTime;
            grant_q     <= 3'b000;
            seg_which_q <= 8'h00;
            seg_data_q  <= 8'h00;
        end else begin
            div_q       <= div_d;
            slot_q      <= slot_d;
            bcnt_q      <= bcnt_d;
            phase_q     <= phase_d;
            started_q   <= started_d;
            hold_q      <= hold_d;
            state_q     <= state_d;
            grant_q     <= grant_d;
            seg_which_q <= seg_which_d;
            seg_data_q  <= seg_data_d;
        end
    end

    assign seg_which_o = seg_which_q;
    assign seg_data_o  = seg_data_q;
    assign owner_o     = state_q;
    assign grant_o     = grant_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Scoreboard bench: frame-level directed stimulus pushes expected display slots
// and grant pulses; independent monitors pop and compare as the DUT presents them.
module tb_seg_display_arbiter;

    localparam logic [31:0] DIG_T = 32'h23A5_9A55;
    localparam logic [31:0] DIG_S = 32'h0123_4567;
    localparam logic [31:0] DIG_A = 32'hABAB_ABAB;
    localparam logic [7:0]  BLK_T = 8'hC0;
    localparam logic [7:0]  BLK_S = 8'h05;
    localparam logic [7:0]  BLK_A = 8'h00;

    typedef struct packed {
        logic [7:0] which;
        logic [7:0] data;
    } disp_t;

    typedef struct packed {
        logic [2:0] grant;
        logic [1:0] owner;
    } gnt_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  req = 3'b001;
    logic [95:0] digits;
    logic [23:0] blink;
    logic [7:0]  seg_data, seg_which;
    logic [1:0]  owner;
    logic [2:0]  grant;

    disp_t dq[$];
    gnt_t  gq[$];
    int    errors = 0;
    int    checks = 0;
    int    fr = 0;
    int    cur_owner = 0;
    bit    mon_en = 1'b0;
    disp_t prev = '0;

    assign digits = {DIG_A, DIG_S, DIG_T};
    assign blink  = {BLK_A, BLK_S, BLK_T};

    seg_display_arbiter #(
        .SCAN_DIV         (4),
        .BLINK_HALF       (64),
        .ALERT_MIN_FRAMES (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req),
        .digits_i    (digits),
        .blink_i     (blink),
        .seg_data_o  (seg_data),
        .seg_which_o (seg_which),
        .owner_o     (owner),
        .grant_o     (grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 8'hFC;
            4'h1: return 8'h60;
            4'h2: return 8'hDA;
            4'h3: return 8'hF2;
            4'h4: return 8'h66;
            4'h5: return 8'hB6;
            4'h6: return 8'hBE;
            4'h7: return 8'hE0;
            4'h8: return 8'hFE;
            4'h9: return 8'hF6;
            4'hA: return 8'h02;
            default: return 8'h00;
        endcase
    endfunction

    function automatic disp_t exp_slot(input int o, input int k, input bit ph);
        logic [31:0] d;
        logic [7:0]  b;
        disp_t       e;
        case (o)
            1:       begin d = DIG_S; b = BLK_S; end
            2:       begin d = DIG_A; b = BLK_A; end
            default: begin d = DIG_T; b = BLK_T; end
        endcase
        e.which = (ph && b[k]) ? 8'h00 : (8'h80 >> k);
        e.data  = glyph(d[4*k +: 4]);
        return e;
    endfunction

    // One scan frame: req=ra from frame start, switched to rb at cycle mid.
    task automatic do_frame(input logic [2:0] ra, input int mid, input logic [2:0] rb,
                            input int nxt);
        bit   ph;
        gnt_t g;
        ph = ((fr / 2) % 2) == 1;
        for (int k = 0; k < 8; k++) begin
            if (!(fr == 0 && k == 0)) dq.push_back(exp_slot(cur_owner, k, ph));
        end
        if (nxt != cur_owner) begin
            g.grant = 3'(1 << nxt);
            g.owner = 2'(nxt);
            gq.push_back(g);
        end
        req = ra;
        for (int c = 0; c < 32; c++) begin
            if (mid != 0 && c == mid) req = rb;
            @(negedge clk);
        end
        cur_owner = nxt;
        fr++;
    endtask

    // Display monitor: every change of the digit/segment pair is one presented slot.
    always @(negedge clk) begin
        disp_t cur;
        disp_t e;
        cur = {seg_which, seg_data};
        if (mon_en && cur != prev) begin
            if (dq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL disp_unexpected: got %h expected none", cur);
            end else begin
                e = dq.pop_front();
                chk("disp", 32'(cur), 32'(e));
            end
        end
        prev = cur;
    end

    // Grant monitor: each pulse must match the next expected ownership change.
    always @(negedge clk) begin
        gnt_t e;
        if (mon_en && grant != 3'b000) begin
            if (gq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL grant_unexpected: got %b expected none", grant);
            end else begin
                e = gq.pop_front();
                chk("grant", 32'(grant), 32'(e.grant));
                chk("grant_owner", 32'(owner), 32'(e.owner));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_which", 32'(seg_which), 32'h00);
        chk("rst_data", 32'(seg_data), 32'h00);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        mon_en = 1'b1;
        rst = 1'b1;

        do_frame(3'b001, 0,  3'b001, 0);
        do_frame(3'b001, 0,  3'b001, 0);
        do_frame(3'b001, 0,  3'b001, 0);   // blink phase 1 on time digits
        do_frame(3'b101, 10, 3'b001, 0);   // alert pulse misses frame end
        do_frame(3'b001, 10, 3'b011, 1);   // stopwatch raised mid-frame
        do_frame(3'b011, 0,  3'b011, 1);
        do_frame(3'b010, 31, 3'b110, 2);   // alert only on frame-end cycle
        do_frame(3'b010, 0,  3'b010, 2);
        do_frame(3'b010, 0,  3'b010, 2);
        do_frame(3'b010, 0,  3'b010, 1);   // hold expires, back to stopwatch
        do_frame(3'b000, 0,  3'b000, 0);
        do_frame(3'b111, 0,  3'b111, 2);   // priority straight to alert
        do_frame(3'b001, 0,  3'b001, 2);
        do_frame(3'b001, 0,  3'b001, 2);
        do_frame(3'b001, 0,  3'b001, 0);
        do_frame(3'b100, 0,  3'b100, 2);

        // Frame 16: alert owns the display; reset lands after slot 3 is shown.
        for (int k = 0; k < 4; k++) dq.push_back(exp_slot(2, k, 1'b0));
        dq.push_back('0);
        req = 3'b100;
        repeat (13) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_which", 32'(seg_which), 32'h00);
        chk("mid_rst_data", 32'(seg_data), 32'h00);
        chk("mid_rst_owner", 32'(owner), 32'd0);
        chk("mid_rst_grant", 32'(grant), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        fr = 0;
        cur_owner = 0;
        do_frame(3'b100, 0, 3'b100, 2);
        do_frame(3'b000, 0, 3'b000, 2);
        mon_en = 1'b0;

        chk("disp_queue_empty", 32'(dq.size()), 32'd0);
        chk("grant_queue_empty", 32'(gq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
